pp_column_feeder: RTL



---
 rtl/pp_column_feeder.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/pp_column_feeder.sv
// ============================================================================
// pp_column_feeder : serialises 24x24 AND-array partial products by column.
// Rev 1.0
// ============================================================================
`default_nettype none

module pp_column_feeder (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [23:0] a,
   input  logic [23:0] b,
   output logic        src0_,
   output logic        src1_,
   output logic        src2_,
   output logic        src3_,
   output logic        src4_,
   output logic        src5_,
   output logic        src6_,
   output logic        src7_,
   output logic        src8_,
   output logic        src9_,
   output logic        src10_,
   output logic        src11_,
   output logic        src12_,
   output logic        src13_,
   output logic        src14_,
   output logic        src15_,
   output logic        src16_,
   output logic        src17_,
   output logic        src18_,
   output logic        src19_,
   output logic        src20_,
   output logic        src21_,
   output logic        src22_,
   output logic        src23_,
   output logic        src24_,
   output logic        src25_,
   output logic        src26_,
   output logic        src27_,
   output logic        src28_,
   output logic        src29_,
   output logic        src30_,
   output logic        src31_,
   output logic        src32_,
   output logic        src33_,
   output logic        src34_,
   output logic        src35_,
   output logic        src36_,
   output logic        src37_,
   output logic        src38_,
   output logic        src39_,
   output logic        src40_,
   output logic        src41_,
   output logic        src42_,
   output logic        src43_,
   output logic        src44_,
   output logic        src45_,
   output logic        src46_,
   output logic        out_valid
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t      state;
   logic [4:0]  t;
   logic [23:0] a_reg;
   logic [23:0] b_reg;
   logic [46:0] src;

   // Reset overrides a same-cycle accept, so readiness is masked by rst.
   assign in_ready = ~rst & (state != SHIFT);

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         t         <= 5'd0;
         a_reg     <= 24'd0;
         b_reg     <= 24'd0;
         out_valid <= 1'b0;
      end else begin
         out_valid <= 1'b0;
         case (state)
            IDLE, DONE: begin
               if (in_valid) begin
                  a_reg <= a;
                  b_reg <= b;
                  t     <= 5'd0;
                  state <= SHIFT;
               end else begin
                  state <= IDLE;
               end
            end
            SHIFT: begin
               if (t == 5'd23) begin
                  state     <= DONE;
                  out_valid <= 1'b1;
               end else begin
                  t <= t + 5'd1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Column k stays 0 until its window opens, then walks i upward from lo_k.
   // Indices are mod-32; the true b index k-i is always within 0..23.
   for (genvar k = 0; k < 47; k++) begin : g_col
      localparam int         H  = (k + 1 < 47 - k) ? k + 1 : 47 - k;
      localparam int         LO = (k > 23) ? k - 23 : 0;
      localparam logic [4:0] W  = 5'(24 - H);
      localparam logic [4:0] L5 = 5'(LO);
      localparam logic [4:0] K5 = 5'(k);
      logic [4:0] ai;
      logic [4:0] bi;
      always_comb begin
         ai     = L5 + (t - W);
         bi     = K5 - ai;
         src[k] = (state == SHIFT) && (t >= W) && a_reg[ai] && b_reg[bi];
      end
   end

   assign src0_  = src[0];
   assign src1_  = src[1];
   assign src2_  = src[2];
   assign src3_  = src[3];
   assign src4_  = src[4];
   assign src5_  = src[5];
   assign src6_  = src[6];
   assign src7_  = src[7];
   assign src8_  = src[8];
   assign src9_  = src[9];
   assign src10_ = src[10];
   assign src11_ = src[11];
   assign src12_ = src[12];
   assign src13_ = src[13];
   assign src14_ = src[14];
   assign src15_ = src[15];
   assign src16_ = src[16];
   assign src17_ = src[17];
   assign src18_ = src[18];
   assign src19_ = src[19];
   assign src20_ = src[20];
   assign src21_ = src[21];
   assign src22_ = src[22];
   assign src23_ = src[23];
   assign src24_ = src[24];
   assign src25_ = src[25];
   assign src26_ = src[26];
   assign src27_ = src[27];
   assign src28_ = src[28];
   assign src29_ = src[29];
   assign src30_ = src[30];
   assign src31_ = src[31];
   assign src32_ = src[32];
   assign src33_ = src[33];
   assign src34_ = src[34];
   assign src35_ = src[35];
   assign src36_ = src[36];
   assign src37_ = src[37];
   assign src38_ = src[38];
   assign src39_ = src[39];
   assign src40_ = src[40];
   assign src41_ = src[41];
   assign src42_ = src[42];
   assign src43_ = src[43];
   assign src44_ = src[44];
   assign src45_ = src[45];
   assign src46_ = src[46];

endmodule

`default_nettype wire
